// File: rtl/dk_sound_trigger.sv
// Sound trigger driver: 74LS259-style latch, sample-strobe generator and per-channel hold stretchers.
// Optional status readback (busy, latch_q) when DK_TRIGGER_STATUS_EN is defined.
module dk_sound_trigger #(
   parameter int unsigned CLOCK_RATE       = 1000000,
   parameter int unsigned SAMPLE_RATE      = 48000,
   parameter int unsigned MIN_HOLD_SAMPLES = 480,
   parameter logic [7:0]  INVERT_MASK      = 8'h00
) (
   input  logic       clk,
   input  logic       I_RSTn,
   input  logic       cpu_we,
   input  logic [2:0] cpu_addr,
   input  logic       cpu_data,
   input  logic       latch_clr,
   output logic       audio_clk_en,
   output logic [7:0] trigger_en
`ifdef DK_TRIGGER_STATUS_EN
   ,
   output logic [7:0] busy,
   output logic [7:0] latch_q
`endif
);

   localparam int          CW        = (MIN_HOLD_SAMPLES == 0) ? 1 : $clog2(MIN_HOLD_SAMPLES + 1);
   localparam int unsigned HOLD_LOAD = (MIN_HOLD_SAMPLES == 0) ? 0 : MIN_HOLD_SAMPLES - 1;

   typedef enum logic {
      CH_IDLE,
      CH_ACTIVE
   } ch_state_t;

   logic [31:0]   acc_q;
   logic [32:0]   acc_sum;
   logic          acc_wrap;
   logic [7:0]    latch;
   logic [7:0]    rtg_q;
   logic [7:0]    rtg_d;
   logic [7:0]    rtg_set;
   logic [7:0]    active_d;
   ch_state_t     state_q [8];
   ch_state_t     state_d [8];
   logic [CW-1:0] cnt_q   [8];
   logic [CW-1:0] cnt_d   [8];

   // Phase accumulator: exact long-term SAMPLE_RATE/CLOCK_RATE strobe ratio.
   assign acc_sum  = {1'b0, acc_q} + 33'(SAMPLE_RATE);
   assign acc_wrap = (acc_sum >= 33'(CLOCK_RATE));

   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         acc_q        <= '0;
         audio_clk_en <= 1'b0;
      end else begin
         audio_clk_en <= acc_wrap;
         if (acc_wrap) begin
            acc_q <= 32'(acc_sum - 33'(CLOCK_RATE));
         end else begin
            acc_q <= acc_sum[31:0];
         end
      end
   end

   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         latch <= '0;
      end else if (latch_clr) begin
         latch <= '0;
      end else if (cpu_we) begin
         latch[cpu_addr] <= cpu_data;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < 8; i++) begin
         state_d[i]  = state_q[i];
         cnt_d[i]    = cnt_q[i];
         rtg_d[i]    = rtg_q[i];
         rtg_set[i]  = cpu_we && !latch_clr && cpu_data &&
                       (cpu_addr == 3'(i)) && (state_q[i] == CH_ACTIVE);
         if (audio_clk_en) begin
            unique case (state_q[i])
               CH_IDLE: begin
                  rtg_d[i] = 1'b0;
                  if (latch[i]) begin
                     state_d[i] = CH_ACTIVE;
                     cnt_d[i]   = CW'(HOLD_LOAD);
                  end
               end
               CH_ACTIVE: begin
                  if (rtg_q[i]) begin
                     cnt_d[i] = CW'(HOLD_LOAD);
                     rtg_d[i] = 1'b0;
                  end else if (cnt_q[i] != '0) begin
                     cnt_d[i] = cnt_q[i] - CW'(1);
                  end else if (!latch[i]) begin
                     state_d[i] = CH_IDLE;
                  end
               end
               default: state_d[i] = CH_IDLE;
            endcase
         end
         // A fresh retrigger write wins over consumption on the same edge.
         if (rtg_set[i]) begin
            rtg_d[i] = 1'b1;
         end
         active_d[i] = (state_d[i] == CH_ACTIVE);
      end
   end

   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         rtg_q <= '0;
         for (int unsigned i = 0; i < 8; i++) begin
            state_q[i] <= CH_IDLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         rtg_q <= rtg_d;
         for (int unsigned i = 0; i < 8; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         trigger_en <= INVERT_MASK;
      end else if (audio_clk_en) begin
         trigger_en <= active_d ^ INVERT_MASK;
      end
   end

`ifdef DK_TRIGGER_STATUS_EN
   always_comb begin
      for (int unsigned i = 0; i < 8; i++) begin
         busy[i] = (state_q[i] == CH_ACTIVE);
      end
   end
   assign latch_q = latch;
`endif

endmodule

// File: tb/tb_dk_sound_trigger.sv
// Directed bench for dk_sound_trigger: strobe rate, hold stretching, retrigger, clear priority, polarity, reset.
module tb_dk_sound_trigger;

   logic       clk = 1'b0;
   logic       I_RSTn = 1'b0;
   logic       cpu_we = 1'b0;
   logic [2:0] cpu_addr = '0;
   logic       cpu_data = 1'b0;
   logic       latch_clr = 1'b0;

   logic       en_dut, en_inv, en_zero;
   logic [7:0] trig_dut, trig_inv, trig_zero;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   dk_sound_trigger #(
      .CLOCK_RATE(1000000), .SAMPLE_RATE(48000), .MIN_HOLD_SAMPLES(4), .INVERT_MASK(8'h00)
   ) u_dut (
      .clk(clk), .I_RSTn(I_RSTn), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .latch_clr(latch_clr), .audio_clk_en(en_dut), .trigger_en(trig_dut)
   );

   dk_sound_trigger #(
      .CLOCK_RATE(1000000), .SAMPLE_RATE(48000), .MIN_HOLD_SAMPLES(4), .INVERT_MASK(8'h01)
   ) u_inv (
      .clk(clk), .I_RSTn(I_RSTn), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .latch_clr(latch_clr), .audio_clk_en(en_inv), .trigger_en(trig_inv)
   );

   dk_sound_trigger #(
      .CLOCK_RATE(1000000), .SAMPLE_RATE(48000), .MIN_HOLD_SAMPLES(0), .INVERT_MASK(8'h00)
   ) u_zero (
      .clk(clk), .I_RSTn(I_RSTn), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .latch_clr(latch_clr), .audio_clk_en(en_zero), .trigger_en(trig_zero)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench just after an edge where audio_clk_en is high: the next edge is a strobe edge.
   task automatic wait_en();
      int n = 0;
      while (en_dut !== 1'b1 && n < 64) begin
         step();
         n++;
      end
      if (en_dut !== 1'b1) begin
         vectors++;
         errors++;
         $display("FAIL strobe_timeout: audio_clk_en=%b required=1 within 64 cycles", en_dut);
      end
   endtask

   task automatic strobe_edge();
      wait_en();
      step();
   endtask

   task automatic cpu_write(input logic [2:0] a, input logic d);
      cpu_we   = 1'b1;
      cpu_addr = a;
      cpu_data = d;
      step();
      cpu_we   = 1'b0;
   endtask

   task automatic test_reset();
      I_RSTn = 1'b0;
      repeat (3) step();
      vectors++;
      if (trig_dut !== 8'h00) begin
         errors++;
         $display("FAIL reset_trig: got %h required %h", trig_dut, 8'h00);
      end
      vectors++;
      if (trig_inv !== 8'h01) begin
         errors++;
         $display("FAIL reset_trig_inv: got %h required %h", trig_inv, 8'h01);
      end
      vectors++;
      if (en_dut !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobe: got %b required %b", en_dut, 1'b0);
      end
      I_RSTn = 1'b1;
   endtask

   task automatic test_strobe_rate();
      int count = 0;
      int bad_gap = 0;
      int last = -1;
      for (int k = 1; k <= 10000; k++) begin
         step();
         if (en_dut === 1'b1) begin
            count++;
            if (last >= 0 && (k - last) != 20 && (k - last) != 21) bad_gap++;
            last = k;
         end
      end
      vectors++;
      if (count != 480) begin
         errors++;
         $display("FAIL strobe_count: got %0d required %0d", count, 480);
      end
      vectors++;
      if (bad_gap != 0) begin
         errors++;
         $display("FAIL strobe_spacing: got %0d bad gaps required %0d", bad_gap, 0);
      end
   endtask

   task automatic test_short_pulse();
      wait_en();
      repeat (19) step();
      cpu_write(3'd0, 1'b1);
      vectors++;
      if (trig_dut !== 8'h00) begin
         errors++;
         $display("FAIL pulse_pre: got %h required %h", trig_dut, 8'h00);
      end
      step();
      cpu_write(3'd0, 1'b0);
      vectors++;
      if (trig_dut !== 8'h01) begin
         errors++;
         $display("FAIL pulse_rise: got %h required %h", trig_dut, 8'h01);
      end
      for (int s = 2; s <= 4; s++) begin
         strobe_edge();
         vectors++;
         if (trig_dut !== 8'h01) begin
            errors++;
            $display("FAIL pulse_hold%0d: got %h required %h", s, trig_dut, 8'h01);
         end
      end
      strobe_edge();
      vectors++;
      if (trig_dut !== 8'h00) begin
         errors++;
         $display("FAIL pulse_fall: got %h required %h", trig_dut, 8'h00);
      end
   endtask

   task automatic test_long_hold();
      strobe_edge();
      vectors++;
      if (trig_dut !== 8'h00) begin
         errors++;
         $display("FAIL hold_idle: got %h required %h", trig_dut, 8'h00);
      end
      cpu_write(3'd3, 1'b1);
      for (int s = 1; s <= 10; s++) begin
         strobe_edge();
         vectors++;
         if (trig_dut !== 8'h08) begin
            errors++;
            $display("FAIL hold_s%0d: got %h required %h", s, trig_dut, 8'h08);
         end
      end
      cpu_write(3'd3, 1'b0);
      strobe_edge();
      vectors++;
      if (trig_dut !== 8'h00) begin
         errors++;
         $display("FAIL hold_fall: got %h required %h", trig_dut, 8'h00);
      end
   endtask

   task automatic test_retrigger();
      strobe_edge();
      cpu_write(3'd2, 1'b1);
      for (int s = 1; s <= 7; s++) begin
         strobe_edge();
         vectors++;
         if (trig_dut !== 8'h04) begin
            errors++;
            $display("FAIL retrig_s%0d: got %h required %h", s, trig_dut, 8'h04);
         end
         if (s == 3) begin
            cpu_write(3'd2, 1'b1);
            latch_clr = 1'b1;
            step();
            latch_clr = 1'b0;
         end
      end
      strobe_edge();
      vectors++;
      if (trig_dut !== 8'h00) begin
         errors++;
         $display("FAIL retrig_fall: got %h required %h", trig_dut, 8'h00);
      end
   endtask

   task automatic test_clear_priority();
      strobe_edge();
      cpu_we    = 1'b1;
      cpu_addr  = 3'd1;
      cpu_data  = 1'b1;
      latch_clr = 1'b1;
      step();
      cpu_we    = 1'b0;
      latch_clr = 1'b0;
      for (int s = 1; s <= 3; s++) begin
         strobe_edge();
         vectors++;
         if (trig_dut !== 8'h00) begin
            errors++;
            $display("FAIL clr_we_s%0d: got %h required %h", s, trig_dut, 8'h00);
         end
         vectors++;
         if (trig_inv !== 8'h01) begin
            errors++;
            $display("FAIL clr_we_inv_s%0d: got %h required %h", s, trig_inv, 8'h01);
         end
      end
   endtask

   task automatic test_zero_hold();
      strobe_edge();
      cpu_write(3'd5, 1'b1);
      strobe_edge();
      vectors++;
      if (trig_zero !== 8'h20) begin
         errors++;
         $display("FAIL zero_rise: got %h required %h", trig_zero, 8'h20);
      end
      strobe_edge();
      vectors++;
      if (trig_zero !== 8'h20) begin
         errors++;
         $display("FAIL zero_hold: got %h required %h", trig_zero, 8'h20);
      end
      cpu_write(3'd5, 1'b0);
      strobe_edge();
      vectors++;
      if (trig_zero !== 8'h00) begin
         errors++;
         $display("FAIL zero_fall: got %h required %h", trig_zero, 8'h00);
      end
      repeat (6) strobe_edge();
   endtask

   task automatic test_reset_mid_hold();
      strobe_edge();
      cpu_write(3'd0, 1'b1);
      strobe_edge();
      strobe_edge();
      cpu_write(3'd0, 1'b1);
      #2;
      I_RSTn = 1'b0;
      #1;
      vectors++;
      if (trig_dut !== 8'h00) begin
         errors++;
         $display("FAIL midrst_trig: got %h required %h", trig_dut, 8'h00);
      end
      vectors++;
      if (trig_inv !== 8'h01) begin
         errors++;
         $display("FAIL midrst_trig_inv: got %h required %h", trig_inv, 8'h01);
      end
      vectors++;
      if (en_dut !== 1'b0) begin
         errors++;
         $display("FAIL midrst_strobe: got %b required %b", en_dut, 1'b0);
      end
      repeat (3) step();
      I_RSTn = 1'b1;
      for (int s = 1; s <= 3; s++) begin
         strobe_edge();
         vectors++;
         if (trig_dut !== 8'h00) begin
            errors++;
            $display("FAIL midrst_after_s%0d: got %h required %h", s, trig_dut, 8'h00);
         end
      end
   endtask

   initial begin
      test_reset();
      test_strobe_rate();
      test_short_pulse();
      test_long_hold();
      test_retrigger();
      test_clear_priority();
      test_zero_hold();
      test_reset_mid_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/dk_sound_trigger.md
Name: dk_sound_trigger

Overview:
- CPU-side driver for the discrete sound circuits: it produces the trigger enables (such as walk_en) and the sample-rate strobe that those circuits consume.
- Emulates the board's 74LS259 addressable sound latch.
- Stretches each trigger so it stays active for a minimum number of audio samples.
- Aligns every trigger edge to the audio_clk_en sample strobe, which this block also generates.

Parameters:
- CLOCK_RATE, 1000000: system clock frequency in Hz.
- SAMPLE_RATE, 48000: audio strobe rate in Hz; must be < CLOCK_RATE.
- MIN_HOLD_SAMPLES, 480: minimum active time per trigger, in audio samples (480 = 10 ms at 48 kHz).
- INVERT_MASK, 8'h00: per-bit output polarity; a 1 makes that trigger_en bit active-low.

Ports:
- clk, input, 1: system clock.
- I_RSTn, input, 1: reset, asynchronous, active-low.
- cpu_we, input, 1: one-cycle latch write strobe.
- cpu_addr, input, 3: latch bit select.
- cpu_data, input, 1: value written to the selected latch bit.
- latch_clr, input, 1: synchronous clear of all latch bits.
- audio_clk_en, output, 1: one-cycle sample strobe, registered.
- trigger_en, output, 8: stretched, sample-aligned trigger outputs; bit 0 = walk_en.

Behaviour:
- Reset (asynchronous, I_RSTn low):
  - latch = 0, accumulator = 0, audio_clk_en = 0.
  - All channels IDLE, all counters 0, all retrigger flags 0.
  - trigger_en = INVERT_MASK.
- Strobe generator: 32-bit phase accumulator, evaluated every clk.
  - If acc + SAMPLE_RATE >= CLOCK_RATE: acc <= acc + SAMPLE_RATE - CLOCK_RATE and audio_clk_en <= 1.
  - Otherwise: acc <= acc + SAMPLE_RATE and audio_clk_en <= 0.
  - Result: exactly SAMPLE_RATE strobes per CLOCK_RATE cycles, no drift.
  - Strobes are never wider than one cycle.
- Latch:
  - cpu_we: latch[cpu_addr] <= cpu_data on that edge.
  - latch_clr: latch <= 0.
  - latch_clr and cpu_we in the same cycle: clear wins and the write is dropped.
- Retrigger flag (per channel):
  - Set by a cpu_we that writes 1 to the channel while the channel is ACTIVE.
  - Cleared when it is consumed.
- Channel FSM (8 identical instances, channel i): states are evaluated only on cycles where audio_clk_en = 1; otherwise all state holds.
  - IDLE, latch[i] = 1: go ACTIVE, cnt <= MIN_HOLD_SAMPLES - 1 (saturating at 0).
  - ACTIVE, retrigger flag set: cnt <= MIN_HOLD_SAMPLES - 1, clear flag, stay ACTIVE.
  - ACTIVE, cnt > 0: cnt <= cnt - 1.
  - ACTIVE, cnt = 0 and latch[i] = 0: go IDLE.
  - ACTIVE, cnt = 0 and latch[i] = 1: stay ACTIVE.
- Counter width: $clog2(MIN_HOLD_SAMPLES + 1), minimum 1 bit.
- Output: trigger_en[i] = (state == ACTIVE) XOR INVERT_MASK[i], registered.
  - Changes only on the edge where audio_clk_en is 1.
- Latency: a latch write at edge N appears on trigger_en at the first audio_clk_en-qualified edge after N.
  - A write that coincides with a strobe edge is seen at the next strobe.
- Minimum active time:
  - A trigger stays active for max(MIN_HOLD_SAMPLES, 1) strobes even if the latch is cleared immediately.
  - It stays active longer for as long as latch[i] remains 1.
- MIN_HOLD_SAMPLES = 0: the channel follows latch[i] with one strobe of latency.
- A pulse shorter than one sample (write 1 then 0 between strobes) is lost; this matches real-hardware sampling.
- Reset mid-operation: everything returns to the reset values immediately; no pending retrigger survives.

Optional Feature:
- DK_TRIGGER_STATUS_EN defined, two extra outputs:
  - busy[7:0]: per-channel ACTIVE state, not inverted.
  - latch_q[7:0]: the raw latch contents.
  - Both reset to 0.
  - Intended for OSD/debug readback.
- DK_TRIGGER_STATUS_EN undefined: these ports and their logic are absent.
- Core behaviour is identical either way.

Test Plan:
- Defaults, run 1,000,000 clk -> exactly 48000 audio_clk_en pulses, each 1 cycle wide, with spacing always 20 or 21 cycles.
- MIN_HOLD_SAMPLES = 4, write addr 0 = 1 then addr 0 = 0 two cycles later -> trigger_en[0] rises at the next strobe, stays 1 for exactly 4 strobes, then falls.
- MIN_HOLD_SAMPLES = 4, write addr 3 = 1 and hold for 10 strobes, then write 0 -> trigger_en[3] = 1 throughout, falls at the first strobe after the 0 write; other bits stay 0.
- MIN_HOLD_SAMPLES = 4, activate ch2, write addr 2 = 1 again after 3 strobes, clear the latch -> 4 further strobes active after the retrigger, 7 in total.
- latch_clr and cpu_we (addr 1 = 1) in the same cycle -> latch stays 0 and trigger_en[1] never rises; with INVERT_MASK = 8'h01, trigger_en = 8'h01 both out of reset and while idle.
- Assert I_RSTn low mid-hold on ch0 -> trigger_en returns to INVERT_MASK asynchronously, audio_clk_en = 0, and there is no activity after release until a new write.
